prefetch_slice_arbiter: RTL and testbench
=========================================

# prefetch_slice_arbiter

Shares one DDR-side AXI read master (AR and R channels) among NUM_SLICES prefetcher slices, each slice being one prefetcher controller instance with its own learned context (burst length and transaction ID). AR requests are granted round-robin and issued through a registered master stage. R beats are routed back by matching `m_r_id` against each slice's learned context ID. Per-slice outstanding-burst counters throttle any slice that reaches MAX_OUTSTANDING.

## Interface

Parameters:
- NUM_SLICES, 4: number of requesting slices (2..16)
- ADDR_BITS, 64: address width
- BURST_LEN_WIDTH, 8: AXI ARLEN width
- TID_WIDTH, 8: AXI ID width
- MAX_OUTSTANDING, 8: per-slice cap on issued but not completed bursts
- LOG_MAX_OUT, 4: counter width; must satisfy 2^LOG_MAX_OUT > MAX_OUTSTANDING

Ports:
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- en  in  1  global enable; when low, all state is frozen
- sl_ar_valid  in  NUM_SLICES  per-slice read request valid
- sl_ar_ready  out  NUM_SLICES  per-slice request accepted
- sl_ar_addr  in  NUM_SLICES*ADDR_BITS  packed; slice i at bits [i*ADDR_BITS +: ADDR_BITS]
- sl_ar_len  in  NUM_SLICES*BURST_LEN_WIDTH  packed burst lengths
- sl_ar_id  in  NUM_SLICES*TID_WIDTH  packed IDs
- sl_ctx_valid  in  NUM_SLICES  slice context learned
- sl_ctx_id  in  NUM_SLICES*TID_WIDTH  learned ID per slice, used for R routing
- sl_r_valid  out  NUM_SLICES  R beat routed to slice
- sl_r_ready  in  NUM_SLICES  slice accepts the beat
- m_ar_valid / m_ar_ready  out / in  1  master AR handshake
- m_ar_addr / m_ar_len / m_ar_id  out  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  master AR payload
- m_r_valid / m_r_ready  in / out  1  master R handshake
- m_r_id  in  TID_WIDTH  beat ID
- m_r_last  in  1  last beat of burst
- out_cnt  out  NUM_SLICES*LOG_MAX_OUT  per-slice outstanding count
- unmatched_cnt  out  16  beats dropped with no owning slice; saturates at 0xFFFF

## Operation

- AR FSM states:
  - AR_IDLE: eligible slices are those with `sl_ar_valid[i] & (out_cnt[i] < MAX_OUTSTANDING)`. If any slice is eligible, grant g is the first eligible slice at or after `rr_ptr`, wrapping around.
    - `sl_ar_ready[g]` is driven combinationally high for exactly this cycle.
    - The payload of slice g is captured into `m_ar_*`.
    - Next state is AR_ISSUE.
  - AR_ISSUE: `m_ar_valid`=1. The payload holds stable until `m_ar_ready`. On the handshake: next state is AR_IDLE, `rr_ptr` ← g+1 mod NUM_SLICES, and `out_cnt[g]`++.
- R routing is purely combinational:
  - match = lowest i with `sl_ctx_valid[i] & sl_ctx_id[i]==m_r_id`.
  - `sl_r_valid[match]` = `m_r_valid`; `m_r_ready` = `sl_r_ready[match]`.
  - No match: `m_r_ready`=1 and the beat is dropped. `unmatched_cnt`++ on each dropped beat.
- `out_cnt[i]` decrements on `m_r_valid & m_r_ready & m_r_last` routed to slice i. The counter never underflows; at 0, the decrement is ignored.
- If a grant increment and a last-beat decrement hit the same slice in the same cycle, the count is unchanged.
- When `sl_ctx_valid[i]` falls, `out_cnt[i]` is not cleared. The slice cleanup path drains the slice first.

## Timing

- Reset values: FSM=AR_IDLE, `rr_ptr`=0, `m_ar_valid`=0, `m_ar_addr/len/id`=0, all `out_cnt`=0, `unmatched_cnt`=0. `sl_ar_ready` is 0 in reset because it is combinational on FSM=AR_IDLE.
- Slice AR handshake to `m_ar_valid` high: 1 cycle. Minimum master AR issue interval: 2 cycles.
- `m_ar_valid` never drops without a handshake, per AXI.
- R path has zero latency.
- With `en`=0: `sl_ar_ready`=0 and no counters change. R routing stays combinational, but the counters do not update.
- Reset asserted mid-burst aborts the AR_ISSUE transaction; the master side is reset together with the arbiter.

## Structure

- Package `prefetch_arb_pkg`:
  - `ar_state_t` enum {AR_IDLE, AR_ISSUE}
  - slice-index width function `$clog2(NUM_SLICES)`
- Sub-module `rr_pick`: parameterised round-robin priority encoder. Inputs: request vector and pointer. Outputs: grant index and any-valid.

## Test plan

- Slices 0 and 2 valid with `m_ar_ready`=1 → grants in order 0, 2, 0, 2. `m_ar_id` and `m_ar_addr` match the granted slice each time.
- Slice 1 issues 8 bursts and no R data returns → `out_cnt[1]`=8 and the 9th request is not granted. One `m_r_last` beat with slice 1's ID → count 7, and the request is granted.
- `m_ar_ready` held low for 5 cycles → `m_ar_valid` and payload stable for all 5 cycles, and `sl_ar_ready` stays 0 for every slice.
- R beat with `m_r_id`=0x3C, slice 3 ctx_id=0x3C, `sl_r_ready[3]`=0 → `m_r_ready`=0 and `sl_r_valid[3]`=1. Raising `sl_r_ready[3]` completes the beat.
- R beat with ID not matching any valid context → `m_r_ready`=1 and `unmatched_cnt` increments by 1.
- Grant to slice 0 and a last beat for slice 0 in the same cycle with count 3 → count remains 3.

Source files
------------

// File: rtl/prefetch_slice_arbiter_pkg.sv
// Shared types and helpers for the prefetch slice arbiter.
//   ar_state_t  : AR-side FSM state encoding
//   slice_idx_w : width of a slice index for a given slice count
package prefetch_arb_pkg;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_t;

    // A single slice still needs a 1-bit index so vectors stay legal.
    function automatic int slice_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prefetch_slice_arbiter_rr_pick.sv
// Round-robin priority encoder.
//   req   : request vector, one bit per slice
//   ptr   : slice with highest priority this cycle
//   grant : first requesting slice at or after ptr, wrapping
//   any   : at least one request is present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    int idx;

    // Scan from the farthest slice back towards ptr so that the last hit
    // written is the closest one at or after ptr.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant = IW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_slice_arbiter.sv
// Shares one AXI read master (AR + R) among NUM_SLICES prefetcher slices.
//   clk, resetN            : clock, asynchronous active-low reset
//   en                     : global enable, freezes all state when low
//   sl_ar_*                : per-slice AR requests (packed payloads)
//   sl_ctx_valid/sl_ctx_id : per-slice learned context used for R routing
//   sl_r_valid/sl_r_ready  : per-slice R handshake
//   m_ar_*                 : registered master AR channel
//   m_r_valid/ready/id/last: master R channel
//   out_cnt                : per-slice outstanding burst counts (packed)
//   unmatched_cnt          : saturating count of dropped unrouted beats
module prefetch_slice_arbiter
    import prefetch_arb_pkg::*;
#(
    parameter int NUM_SLICES      = 4,
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LOG_MAX_OUT     = 4
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 en,
    input  logic [NUM_SLICES-1:0]                sl_ar_valid,
    output logic [NUM_SLICES-1:0]                sl_ar_ready,
    input  logic [NUM_SLICES*ADDR_BITS-1:0]      sl_ar_addr,
    input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
    input  logic [NUM_SLICES*TID_WIDTH-1:0]      sl_ar_id,
    input  logic [NUM_SLICES-1:0]                sl_ctx_valid,
    input  logic [NUM_SLICES*TID_WIDTH-1:0]      sl_ctx_id,
    output logic [NUM_SLICES-1:0]                sl_r_valid,
    input  logic [NUM_SLICES-1:0]                sl_r_ready,
    output logic                                 m_ar_valid,
    input  logic                                 m_ar_ready,
    output logic [ADDR_BITS-1:0]                 m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]           m_ar_len,
    output logic [TID_WIDTH-1:0]                 m_ar_id,
    input  logic                                 m_r_valid,
    output logic                                 m_r_ready,
    input  logic [TID_WIDTH-1:0]                 m_r_id,
    input  logic                                 m_r_last,
    output logic [NUM_SLICES*LOG_MAX_OUT-1:0]    out_cnt,
    output logic [15:0]                          unmatched_cnt
);

    localparam int IW = slice_idx_w(NUM_SLICES);

    ar_state_t             state, state_nxt;
    logic [IW-1:0]         rr_ptr, grant_q, pick_idx, match_idx;
    logic                  pick_any, match_any;
    logic                  capture, issue_done, last_fire, drop;
    logic [NUM_SLICES-1:0] eligible, cnt_inc, cnt_dec;
    logic [LOG_MAX_OUT-1:0] cnt [NUM_SLICES];

    // Slices at their outstanding cap are masked out of arbitration.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SLICES; i++)
            eligible[i] = sl_ar_valid[i] & (cnt[i] < LOG_MAX_OUT'(MAX_OUTSTANDING));
    end

    rr_pick #(.N(NUM_SLICES), .IW(IW)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_nxt   = state;
        sl_ar_ready = '0;
        capture     = 1'b0;
        issue_done  = 1'b0;
        if (en) begin
            case (state)
                AR_IDLE: begin
                    if (pick_any) begin
                        sl_ar_ready[pick_idx] = 1'b1;
                        capture               = 1'b1;
                        state_nxt             = AR_ISSUE;
                    end
                end
                AR_ISSUE: begin
                    if (m_ar_ready) begin
                        issue_done = 1'b1;
                        state_nxt  = AR_IDLE;
                    end
                end
                default: state_nxt = AR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= AR_IDLE;
        else         state <= state_nxt;
    end

    // m_ar_valid is the ISSUE state itself, so it only falls on a handshake.
    assign m_ar_valid = (state == AR_ISSUE);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ar_addr <= '0;
            m_ar_len  <= '0;
            m_ar_id   <= '0;
            grant_q   <= '0;
            rr_ptr    <= '0;
        end else begin
            if (capture) begin
                m_ar_addr <= sl_ar_addr[pick_idx*ADDR_BITS +: ADDR_BITS];
                m_ar_len  <= sl_ar_len[pick_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
                m_ar_id   <= sl_ar_id[pick_idx*TID_WIDTH +: TID_WIDTH];
                grant_q   <= pick_idx;
            end
            if (issue_done)
                rr_ptr <= (grant_q == IW'(NUM_SLICES - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    // R routing: lowest slice whose valid context ID matches owns the beat.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (sl_ctx_valid[i] && (sl_ctx_id[i*TID_WIDTH +: TID_WIDTH] == m_r_id)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
        end
        sl_r_valid = '0;
        m_r_ready  = 1'b1;   // unowned beats are sunk so the bus never stalls
        if (match_any) begin
            sl_r_valid[match_idx] = m_r_valid;
            m_r_ready             = sl_r_ready[match_idx];
        end
    end

    assign last_fire = m_r_valid & m_r_ready & m_r_last & match_any;
    assign drop      = m_r_valid & ~match_any;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            cnt_inc[i] = issue_done & (grant_q == IW'(i));
            cnt_dec[i] = last_fire & (match_idx == IW'(i)) & (cnt[i] != '0);
        end
    end

    // A simultaneous issue and completion on one slice cancel out.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLICES; i++) cnt[i] <= '0;
            unmatched_cnt <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_SLICES; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i]) cnt[i] <= cnt[i] - 1'b1;
            end
            if (drop && (unmatched_cnt != 16'hFFFF))
                unmatched_cnt <= unmatched_cnt + 16'd1;
        end
    end

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < NUM_SLICES; i++)
            out_cnt[i*LOG_MAX_OUT +: LOG_MAX_OUT] = cnt[i];
    end

endmodule

// File: tb/tb_prefetch_slice_arbiter.sv
// Directed bench for prefetch_slice_arbiter: R-routing vector table plus
// hand-written AR/R sequences for arbitration, throttling and corner cases.
module tb_prefetch_slice_arbiter;

    logic         clk;
    logic         resetN;
    logic         en;
    logic [3:0]   sl_ar_valid, sl_ar_ready;
    logic [255:0] sl_ar_addr;
    logic [31:0]  sl_ar_len, sl_ar_id;
    logic [3:0]   sl_ctx_valid;
    logic [31:0]  sl_ctx_id;
    logic [3:0]   sl_r_valid, sl_r_ready;
    logic         m_ar_valid, m_ar_ready;
    logic [63:0]  m_ar_addr;
    logic [7:0]   m_ar_len, m_ar_id;
    logic         m_r_valid, m_r_ready, m_r_last;
    logic [7:0]   m_r_id;
    logic [15:0]  out_cnt;
    logic [15:0]  unmatched_cnt;

    prefetch_slice_arbiter dut (
        .clk(clk), .resetN(resetN), .en(en),
        .sl_ar_valid(sl_ar_valid), .sl_ar_ready(sl_ar_ready),
        .sl_ar_addr(sl_ar_addr), .sl_ar_len(sl_ar_len), .sl_ar_id(sl_ar_id),
        .sl_ctx_valid(sl_ctx_valid), .sl_ctx_id(sl_ctx_id),
        .sl_r_valid(sl_r_valid), .sl_r_ready(sl_r_ready),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_id(m_r_id), .m_r_last(m_r_last),
        .out_cnt(out_cnt), .unmatched_cnt(unmatched_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] addr_tbl [4];
    logic [7:0]  id_tbl   [4];
    logic [7:0]  len_tbl  [4];

    typedef struct {
        logic [3:0]  cv;
        logic [31:0] cid;
        logic        rv;
        logic [7:0]  rid;
        logic [3:0]  rrdy;
        logic [3:0]  e_slrv;
        logic        e_mrdy;
    } rvec_t;

    rvec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cnt_of(input int i);
        return out_cnt[i*4 +: 4];
    endfunction

    task automatic check_payload(input string name, input int s);
        check({name, "_valid"}, m_ar_valid, 1);
        check({name, "_addr"}, m_ar_addr, addr_tbl[s]);
        check({name, "_id"}, m_ar_id, id_tbl[s]);
        check({name, "_len"}, m_ar_len, len_tbl[s]);
    endtask

    initial begin
        addr_tbl = '{64'h0A0A_0000_0000_0A00, 64'h1111_0000_0000_1000,
                     64'h2222_0000_0000_2000, 64'h3333_0000_0000_3000};
        id_tbl   = '{8'h05, 8'h11, 8'h22, 8'h3C};
        len_tbl  = '{8'h01, 8'h03, 8'h07, 8'h0F};

        //            cv       cid           rv    rid    rrdy     e_slrv   e_mrdy
        tbl[0] = '{4'b1111, 32'h3C221105, 1'b1, 8'h22, 4'b0100, 4'b0100, 1'b1};
        tbl[1] = '{4'b1111, 32'h3C221105, 1'b1, 8'h22, 4'b1011, 4'b0100, 1'b0};
        tbl[2] = '{4'b1010, 32'h05050505, 1'b1, 8'h05, 4'b0010, 4'b0010, 1'b1};
        tbl[3] = '{4'b1000, 32'h05050505, 1'b1, 8'h05, 4'b0111, 4'b1000, 1'b0};
        tbl[4] = '{4'b0000, 32'h05050505, 1'b1, 8'h05, 4'b0000, 4'b0000, 1'b1};
        tbl[5] = '{4'b0001, 32'h3C221105, 1'b0, 8'h05, 4'b0000, 4'b0000, 1'b0};
        tbl[6] = '{4'b0111, 32'h3C221105, 1'b1, 8'h3C, 4'b1111, 4'b0000, 1'b1};

        for (int i = 0; i < 4; i++) begin
            sl_ar_addr[i*64 +: 64] = addr_tbl[i];
            sl_ar_id[i*8 +: 8]     = id_tbl[i];
            sl_ar_len[i*8 +: 8]    = len_tbl[i];
        end
        sl_ctx_id    = 32'h3C221105;
        resetN       = 1'b0;
        en           = 1'b0;
        sl_ar_valid  = '0;
        sl_ctx_valid = '0;
        sl_r_ready   = '0;
        m_ar_ready   = 1'b0;
        m_r_valid    = 1'b0;
        m_r_id       = '0;
        m_r_last     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_ar_valid", m_ar_valid, 0);
        check("rst_m_ar_addr", m_ar_addr, 0);
        check("rst_m_ar_id", m_ar_id, 0);
        check("rst_m_ar_len", m_ar_len, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_unmatched", unmatched_cnt, 0);
        check("rst_sl_ar_ready", sl_ar_ready, 0);
        @(negedge clk);
        resetN = 1'b1;
        en     = 1'b1;

        // Round robin between slices 0 and 2
        @(negedge clk);
        m_ar_ready  = 1'b1;
        sl_ar_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", sl_ar_ready, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            @(negedge clk);
            #1;
            check_payload("rr_issue", (k % 2 == 0) ? 0 : 2);
            check("rr_ready_in_issue", sl_ar_ready, 0);
            if (k == 3) sl_ar_valid = '0;
            @(negedge clk);
        end
        #1;
        check("rr_idle_ready", sl_ar_ready, 0);
        check("rr_cnt0", cnt_of(0), 2);
        check("rr_cnt2", cnt_of(2), 2);

        // Slice 1 fills to MAX_OUTSTANDING
        sl_ar_valid = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fill_ready", sl_ar_ready, 4'b0010);
            @(negedge clk);
            #1;
            check_payload("fill_issue", 1);
            @(negedge clk);
        end
        #1;
        check("fill_cnt1", cnt_of(1), 8);
        check("fill_9th_ready", sl_ar_ready, 0);
        @(negedge clk);
        #1;
        check("fill_9th_no_issue", m_ar_valid, 0);
        sl_ctx_valid = 4'b0010;
        sl_r_ready   = 4'b0010;
        m_r_id       = 8'h11;
        m_r_last     = 1'b1;
        m_r_valid    = 1'b1;
        #1;
        check("fill_r_route", sl_r_valid, 4'b0010);
        check("fill_r_ready", m_r_ready, 1);
        @(negedge clk);
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        #1;
        check("fill_cnt1_after_last", cnt_of(1), 7);
        check("fill_regrant_ready", sl_ar_ready, 4'b0010);
        @(negedge clk);
        #1;
        check_payload("fill_regrant_issue", 1);
        sl_ar_valid = '0;
        @(negedge clk);
        #1;
        check("fill_cnt1_back", cnt_of(1), 8);

        // Master stall: payload must hold for 5 cycles
        m_ar_ready  = 1'b0;
        sl_ar_valid = 4'b1001;
        #1;
        check("stall_grant", sl_ar_ready, 4'b1000);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            check_payload("stall_hold", 3);
            check("stall_ready", sl_ar_ready, 0);
            @(negedge clk);
        end
        m_ar_ready  = 1'b1;
        sl_ar_valid = '0;
        #1;
        check("stall_release_valid", m_ar_valid, 1);
        @(negedge clk);
        #1;
        check("stall_done_valid", m_ar_valid, 0);
        check("stall_cnt3", cnt_of(3), 1);

        // Same-cycle issue and completion on slice 0
        sl_ar_valid = 4'b0001;
        #1;
        check("same_pre_ready", sl_ar_ready, 4'b0001);
        @(negedge clk);
        sl_ar_valid = '0;
        @(negedge clk);
        #1;
        check("same_cnt0_pre", cnt_of(0), 3);
        sl_ar_valid = 4'b0001;
        #1;
        check("same_ready", sl_ar_ready, 4'b0001);
        @(negedge clk);
        sl_ar_valid  = '0;
        sl_ctx_valid = 4'b0011;
        sl_r_ready   = 4'b0001;
        m_r_id       = 8'h05;
        m_r_last     = 1'b1;
        m_r_valid    = 1'b1;
        #1;
        check("same_m_ar_valid", m_ar_valid, 1);
        check("same_r_ready", m_r_ready, 1);
        @(negedge clk);
        m_r_valid = 1'b0;
        #1;
        check("same_cnt0", cnt_of(0), 3);

        // Unowned beat is sunk and counted
        sl_ctx_valid = 4'b1111;
        sl_r_ready   = '0;
        m_r_id       = 8'h77;
        m_r_valid    = 1'b1;
        #1;
        check("unm_r_ready", m_r_ready, 1);
        check("unm_sl_r_valid", sl_r_valid, 0);
        @(negedge clk);
        m_r_valid = 1'b0;
        #1;
        check("unm_cnt", unmatched_cnt, 1);

        // Backpressure from slice 3 on ID 0x3C
        m_r_id    = 8'h3C;
        m_r_valid = 1'b1;
        #1;
        check("bp_r_ready", m_r_ready, 0);
        check("bp_sl_r_valid", sl_r_valid, 4'b1000);
        @(negedge clk);
        #1;
        check("bp_cnt3_held", cnt_of(3), 1);
        sl_r_ready = 4'b1000;
        #1;
        check("bp_r_ready_up", m_r_ready, 1);
        @(negedge clk);
        #1;
        check("bp_cnt3_done", cnt_of(3), 0);
        @(negedge clk);
        m_r_valid = 1'b0;
        #1;
        check("bp_cnt3_no_underflow", cnt_of(3), 0);
        check("bp_unm_unchanged", unmatched_cnt, 1);

        // R routing table with en low: routing live, counters frozen
        en          = 1'b0;
        sl_ar_valid = 4'b1111;
        m_r_last    = 1'b1;
        for (int v = 0; v < 7; v++) begin
            sl_ctx_valid = tbl[v].cv;
            sl_ctx_id    = tbl[v].cid;
            m_r_valid    = tbl[v].rv;
            m_r_id       = tbl[v].rid;
            sl_r_ready   = tbl[v].rrdy;
            #1;
            check($sformatf("tbl%0d_sl_r_valid", v), sl_r_valid, tbl[v].e_slrv);
            check($sformatf("tbl%0d_m_r_ready", v), m_r_ready, tbl[v].e_mrdy);
            check($sformatf("tbl%0d_ar_ready", v), sl_ar_ready, 0);
            @(negedge clk);
        end
        m_r_valid   = 1'b0;
        m_r_last    = 1'b0;
        sl_ar_valid = '0;
        #1;
        check("en0_cnt0", cnt_of(0), 3);
        check("en0_cnt1", cnt_of(1), 8);
        check("en0_cnt2", cnt_of(2), 2);
        check("en0_cnt3", cnt_of(3), 0);
        check("en0_unmatched", unmatched_cnt, 1);
        check("en0_m_ar_valid", m_ar_valid, 0);

        // Reset during an outstanding issue
        en          = 1'b1;
        m_ar_ready  = 1'b0;
        sl_ar_valid = 4'b0100;
        @(negedge clk);
        sl_ar_valid = '0;
        #1;
        check_payload("midrst_issue", 2);
        resetN = 1'b0;
        #1;
        check("midrst_valid", m_ar_valid, 0);
        check("midrst_addr", m_ar_addr, 0);
        check("midrst_out_cnt", out_cnt, 0);
        check("midrst_unmatched", unmatched_cnt, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
